// File: rtl/wb_arb_pkg.sv
// Shared parameters, requester IDs and write-port payload for the write-back port arbiter.
package wb_arb_pkg;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned NPORT  = 2;
  localparam int unsigned TAG_W  = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PORT_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  localparam logic [SRC_W-1:0] REQ_ALU0 = SRC_W'(0);
  localparam logic [SRC_W-1:0] REQ_ALU1 = SRC_W'(1);
  localparam logic [SRC_W-1:0] REQ_MEM  = SRC_W'(2);
  localparam logic [SRC_W-1:0] REQ_BR   = SRC_W'(3);

  typedef struct packed {
    logic              vld;
    logic [SRC_W-1:0]  src;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wb_port_t;

  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx);
    return SRC_W'((int'(idx) + 1) % NREQ);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational rotated-priority picker: up to NPORT one-hot grants starting the search at i_ptr.
module rr_pick
  import wb_arb_pkg::*;
(
  input  logic [NREQ-1:0]             i_req,
  input  logic [SRC_W-1:0]            i_ptr,
  output logic [NPORT-1:0][NREQ-1:0]  o_gnt,
  output logic                        o_any,
  output logic [SRC_W-1:0]            o_last
);

  int unsigned w_cnt;
  int unsigned w_idx;

  // Walk requesters in ptr order; each hit fills the next free port.
  always_comb begin
    o_gnt  = '0;
    o_any  = 1'b0;
    o_last = '0;
    w_cnt  = 0;
    w_idx  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = (int'(i_ptr) + i) % NREQ;
      if (i_req[SRC_W'(w_idx)] && (w_cnt < NPORT)) begin
        o_gnt[PORT_W'(w_cnt)][SRC_W'(w_idx)] = 1'b1;
        o_last = SRC_W'(w_idx);
        o_any  = 1'b1;
        w_cnt  = w_cnt + 1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin write-back port arbiter: grants up to NPORT results per cycle, registers them onto the ports.
// Optional build macro WB_ARB_STALL_CNT_EN adds per-requester saturating stall counters (o_stall_cnt).
module wb_port_arbiter
  import wb_arb_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic [NREQ-1:0]           i_req_vld,
  input  logic [NREQ*TAG_W-1:0]     i_req_tag,
  input  logic [NREQ*DATA_W-1:0]    i_req_data,
  output logic [NREQ-1:0]           o_req_rdy,
  output logic [NPORT-1:0]          o_wb_vld,
  output logic [NPORT*TAG_W-1:0]    o_wb_tag,
  output logic [NPORT*DATA_W-1:0]   o_wb_data,
  output logic [NPORT*SRC_W-1:0]    o_wb_src
`ifdef WB_ARB_STALL_CNT_EN
  ,
  output logic [NREQ*16-1:0]        o_stall_cnt
`endif
);

  logic [SRC_W-1:0]            r_ptr;
  wb_port_t                    r_wb [NPORT];
  logic [NREQ-1:0]             w_req;
  logic [NPORT-1:0][NREQ-1:0]  w_gnt;
  logic                        w_any;
  logic [SRC_W-1:0]            w_last;
  wb_port_t                    w_nxt [NPORT];

  // Flush suppresses all grants, so the pointer and ports see an idle cycle.
  assign w_req = i_flush ? '0 : i_req_vld;

  rr_pick u_pick (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_any  (w_any),
    .o_last (w_last)
  );

  always_comb begin
    o_req_rdy = '0;
    for (int k = 0; k < NPORT; k++) begin
      o_req_rdy = o_req_rdy | w_gnt[k];
    end
  end

  // One-hot mux of the granted requester onto each port.
  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      w_nxt[k] = '0;
      for (int r = 0; r < NREQ; r++) begin
        if (w_gnt[k][r]) begin
          w_nxt[k].vld  = 1'b1;
          w_nxt[k].src  = SRC_W'(r);
          w_nxt[k].tag  = i_req_tag[r*TAG_W +: TAG_W];
          w_nxt[k].data = i_req_data[r*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
      for (int k = 0; k < NPORT; k++) r_wb[k] <= '0;
    end else begin
      if (w_any) r_ptr <= rr_next(w_last);
      for (int k = 0; k < NPORT; k++) begin
        r_wb[k].vld <= w_nxt[k].vld;
        if (w_nxt[k].vld) begin
          r_wb[k].src  <= w_nxt[k].src;
          r_wb[k].tag  <= w_nxt[k].tag;
          r_wb[k].data <= w_nxt[k].data;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      o_wb_vld[k]                     = r_wb[k].vld;
      o_wb_src[k*SRC_W +: SRC_W]      = r_wb[k].src;
      o_wb_tag[k*TAG_W +: TAG_W]      = r_wb[k].tag;
      o_wb_data[k*DATA_W +: DATA_W]   = r_wb[k].data;
    end
  end

`ifdef WB_ARB_STALL_CNT_EN
  logic [NREQ-1:0][15:0] r_stall;

  // Counts cycles a result waited without a grant; cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall <= '0;
    end else begin
      for (int r = 0; r < NREQ; r++) begin
        if (i_req_vld[r] && !o_req_rdy[r] && (r_stall[r] != 16'hFFFF))
          r_stall[r] <= r_stall[r] + 16'd1;
      end
    end
  end

  assign o_stall_cnt = r_stall;
`endif

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the physical register file's write-back ports among the execute units (ALU0, ALU1, MEM, BR). Each cycle it picks up to NPORT of NREQ pending results in round-robin order and returns a ready to each winner. Winners are registered onto the write ports one cycle later, where they feed the regfile, the busy table and the ROB completion logic. Losers hold their results until they are granted.

## Interface
- NREQ, 4, number of requesting execute units
- NPORT, 2, number of regfile write ports (1..NREQ)
- TAG_W, 7, physical register tag width
- DATA_W, 32, result width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock, synchronous and active-high
- i_flush  in  1  pipeline kill (mispredict/exception)
- i_req_vld  in  NREQ  result pending, one bit per requester
- i_req_tag  in  NREQ*TAG_W  destination physical tag; requester r occupies slice [r*TAG_W +: TAG_W]
- i_req_data  in  NREQ*DATA_W  result data, sliced the same way
- o_req_rdy  out  NREQ  grant; a transfer happens when vld & rdy
- o_wb_vld  out  NPORT  write-port enable
- o_wb_tag  out  NPORT*TAG_W  write address per port
- o_wb_data  out  NPORT*DATA_W  write data per port
- o_wb_src  out  NPORT*2  requester index per port (ceil(log2 NREQ) bits each)

## Operation
- State: rotating pointer ptr (0..NREQ-1); output registers for each port.
- Pick order: ptr, ptr+1, … wrapping mod NREQ.
  - The first valid requester in that order goes to port 0, the second to port 1, and so on, up to NPORT grants.
  - Port k is filled only if ports 0..k-1 are filled.
- o_req_rdy is combinational from i_req_vld, ptr and i_flush.
  - o_req_rdy[r] = 1 only when r is granted this cycle.
  - o_req_rdy never depends on anything a requester computes from o_req_rdy.
- Requester rule: vld, tag and data stay stable while vld=1 and rdy=0. vld may drop only after the transfer.
- Pointer update:
  - If at least one grant is made, ptr <= (index of last granted requester + 1) mod NREQ.
  - If no grant is made, ptr is unchanged.
  - This makes starvation impossible: every valid requester is granted within ceil(NREQ/NPORT) cycles.
- Flush:
  - The cycle i_flush=1: all o_req_rdy=0 and no grant is made.
  - Next edge: o_wb_vld <= 0, regardless of what would have been registered.
  - ptr is unchanged.
- Boundary cases:
  - No requests: all rdy=0, o_wb_vld=0 next cycle, ptr held.
  - Exactly NPORT requests: all are granted.
  - All NREQ requests valid: ptr advances by NPORT mod NREQ.
  - Wrap-around: if ptr=3 and requesters 3 and 0 are valid, 3 goes to port 0, 0 goes to port 1, and ptr becomes 1.
- Reset: ptr=0, o_wb_vld=0, o_wb_tag=0, o_wb_data=0, o_wb_src=0. Reset takes priority over i_flush. Reset asserted mid-stream drops any pending grant.

## Timing
- Grant is in cycle N (combinational o_req_rdy).
- Write-port outputs are valid after edge N+1 and last exactly one cycle, unless re-granted.
- Latency request→write enable: 1 cycle when uncontended.
- A requester may present a new result in the cycle after its transfer. Back-to-back grants to the same requester are allowed if the pointer and contention permit.
- i_flush, and i_rst at the edge, override a grant made in the same cycle.

## Configuration
- WB_ARB_STALL_CNT_EN
  - Defined: adds output o_stall_cnt, NREQ*16 bits. Counter r increments on each cycle with vld[r]=1 and rdy[r]=0, saturates at 16'hFFFF, and clears on i_rst only.
  - Undefined: port and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Shared package wb_arb_pkg:
  - localparams NREQ, NPORT, SRC_W.
  - Requester IDs REQ_ALU0=0, REQ_ALU1=1, REQ_MEM=2, REQ_BR=3.
  - Helper function rr_next(idx) = (idx+1) mod NREQ.
- Sub-module rr_pick: purely combinational rotated priority picker.
  - Inputs: request vector, pointer.
  - Outputs: NPORT one-hot grant vectors plus last-grant index.
  - wb_port_arbiter holds all state and the output registers.

## Test plan
- Reset, then idle: o_wb_vld=0, o_wb_tag=0, ptr=0; rdy=0 for 5 cycles.
- Single request: req 2 valid (tag 0x15, data 0xDEADBEEF) → rdy[2]=1 that cycle; next cycle port0 = {vld=1, tag 0x15, data 0xDEADBEEF, src 2}, port1 vld=0; ptr=3.
- All four valid and held: grants follow {0,1}, {2,3}, {0,1}; each requester is granted every 2 cycles; ptr sequence is 0→2→0.
- Wrap-around: ptr=3, requesters 0 and 3 valid → port0 src 3, port1 src 0; ptr=1.
- Flush in a cycle with requests 1 and 2 valid → rdy=0000; o_wb_vld=00 next cycle; both are granted the cycle after flush drops.
- With WB_ARB_STALL_CNT_EN: all four valid for 10 cycles → o_stall_cnt = 5 for each requester. Forcing counter 0 to 0xFFFE plus 3 stall cycles → 0xFFFF.
